// File: rtl/cnn_conv_accumulator.sv
// cnn_conv_accumulator
//
// Multiply-accumulate stage behind the CNN data controller. Every enabled cycle
// one pixel/weight pair is multiplied and added into the accumulator selected by
// cnt. On the last kernel tap (pos == POS_MAX-1) the completed sum for that
// channel is saturated to OUT_W bits and presented with a one-cycle strobe.
//
// Ports:
//   clk        - clock, rising edge
//   rst_b      - asynchronous active-low reset
//   en         - operands valid this cycle
//   cnt        - channel index, 0..CNT_MAX-1
//   pos        - kernel tap index, 0..POS_MAX-1
//   pixel      - signed activation
//   weight     - signed weight for (cnt, pos)
//   out_valid  - one-cycle strobe, result present
//   out_ch     - channel of the current result (holds while out_valid is low)
//   out_data   - signed saturated result (holds while out_valid is low)
//   frame_done - one-cycle strobe with the result for channel CNT_MAX-1
//
// Build option:
//   CNN_ACC_RELU_EN - when defined, negative sums are forced to zero before
//                     saturation. Timing is identical in both builds.

module cnn_conv_accumulator #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CNT_MAX = 32,
   parameter int unsigned POS_MAX = 9,
   parameter int unsigned ACC_W   = 20,
   parameter int unsigned OUT_W   = 16,
   parameter int unsigned CNT_W   = 5,
   parameter int unsigned POS_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     en,
   input  logic [CNT_W-1:0]         cnt,
   input  logic [POS_W-1:0]         pos,
   input  logic signed [DATA_W-1:0] pixel,
   input  logic signed [DATA_W-1:0] weight,
   output logic                     out_valid,
   output logic [CNT_W-1:0]         out_ch,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     frame_done
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   // Stage 1 registers
   logic signed [PROD_W-1:0] p1_q;
   logic [CNT_W-1:0]         c1_q;
   logic [POS_W-1:0]         pos1_q;
   logic                     v1_q;

   // Per-channel accumulators
   logic signed [ACC_W-1:0]  acc_q [CNT_MAX];

   logic signed [PROD_W-1:0] prod;
   logic                     in_range;
   logic signed [ACC_W-1:0]  p_ext;
   logic signed [ACC_W-1:0]  acc_rd;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  acc_wr;
   logic                     tap_first;
   logic                     tap_last;
   logic signed [ACC_W-1:0]  sat_in;
   logic [ACC_W-OUT_W:0]     sat_hi;
   logic signed [OUT_W-1:0]  sat_val;

   always_comb begin
      prod      = pixel * weight;
      in_range  = (32'(cnt) < CNT_MAX) && (32'(pos) < POS_MAX);

      p_ext     = {{(ACC_W - PROD_W){p1_q[PROD_W-1]}}, p1_q};
      acc_rd    = acc_q[c1_q];
      sum       = acc_rd + p_ext;
      tap_first = (pos1_q == '0);
      tap_last  = (32'(pos1_q) == POS_MAX - 1);
      // Tap 0 restarts the channel so stale content from an aborted frame never leaks.
      acc_wr    = tap_first ? p_ext : sum;

`ifdef CNN_ACC_RELU_EN
      sat_in = acc_wr[ACC_W-1] ? '0 : acc_wr;
`else
      sat_in = acc_wr;
`endif

      // Value fits in OUT_W bits when all bits from the OUT_W sign bit upward agree.
      sat_hi = sat_in[ACC_W-1:OUT_W-1];
      if ((sat_hi == '0) || (sat_hi == '1)) begin
         sat_val = sat_in[OUT_W-1:0];
      end else if (sat_in[ACC_W-1]) begin
         sat_val = {1'b1, {(OUT_W - 1){1'b0}}};
      end else begin
         sat_val = {1'b0, {(OUT_W - 1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         p1_q       <= '0;
         c1_q       <= '0;
         pos1_q     <= '0;
         v1_q       <= 1'b0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_data   <= '0;
         frame_done <= 1'b0;
         for (int i = 0; i < int'(CNT_MAX); i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         // Stage 1: capture product and indices; bad indices simply never go valid.
         if (en) begin
            p1_q   <= prod;
            c1_q   <= cnt;
            pos1_q <= pos;
            v1_q   <= in_range;
         end else begin
            v1_q   <= 1'b0;
         end

         // Stage 2: read-modify-write in one cycle, so back-to-back same channel is safe.
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (v1_q) begin
            acc_q[c1_q] <= acc_wr;
            if (tap_last) begin
               out_valid  <= 1'b1;
               out_ch     <= c1_q;
               out_data   <= sat_val;
               frame_done <= (32'(c1_q) == CNT_MAX - 1);
            end
         end
      end
   end

endmodule
